// File: rtl/pencoder_seq.sv
// rtl/pencoder_seq.sv - sequential MSB-first priority encoder with valid/ready handshake
//
// Optional feature macro: PENC_ZERO_TOKEN_EN (a zero mask emits one out_zero beat).
//
// Ports:
//   clk        clock, rising edge
//   reset      synchronous active-high reset
//   in_valid   a mask is offered
//   in_ready   block accepts a mask this cycle
//   in_mask    WIDTH-bit mask to encode
//   out_valid  out_idx/out_seq/out_last hold a valid beat
//   out_ready  consumer takes the beat
//   out_idx    MSB-relative index of the leading one (bit WIDTH-1 -> 0)
//   out_seq    ordinal of this beat within the current mask
//   out_last   final beat of the current mask
//   out_zero   zero-mask token beat (PENC_ZERO_TOKEN_EN only)
//   busy       FSM is in BUSY
module pencoder_seq #(
  parameter int WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH),
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [CNT_W-1:0] out_seq,
  output logic             out_last,
`ifdef PENC_ZERO_TOKEN_EN
  output logic             out_zero,
`endif
  output logic             busy
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [WIDTH-1:0] work_mask;
  logic [CNT_W-1:0] seq;
`ifdef PENC_ZERO_TOKEN_EN
  logic             zero_tok;
`endif

  logic [IDX_W-1:0] lead_pos;
  logic [WIDTH-1:0] lead_oh;
  logic             has_bits;
  logic             one_hot;
  logic             fire;
  logic             accept;

  // Leading-one finder: the loop runs upward so the highest set bit wins.
  always_comb begin
    lead_pos = '0;
    lead_oh  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (work_mask[i]) begin
        lead_pos   = IDX_W'(i);
        lead_oh    = '0;
        lead_oh[i] = 1'b1;
      end
    end
  end

  assign has_bits = (work_mask != '0);
  assign one_hot  = has_bits && ((work_mask & (work_mask - WIDTH'(1))) == '0);

  // All outputs are forced to their reset values while reset is high,
  // not just from the edge after it is sampled.
  assign busy      = (state == BUSY) && !reset;
  assign out_valid = busy;
  assign out_idx   = (busy && has_bits) ? (IDX_W'(WIDTH - 1) - lead_pos) : '0;
  assign out_seq   = busy ? seq : '0;
`ifdef PENC_ZERO_TOKEN_EN
  assign out_last  = busy && (one_hot || zero_tok);
  assign out_zero  = busy && zero_tok;
`else
  assign out_last  = busy && one_hot;
`endif

  // Accepting on the last-beat cycle lets masks run back to back with no bubble;
  // this makes in_ready combinationally dependent on out_ready.
  assign in_ready = !reset && ((state == IDLE) || (busy && out_last && out_ready));
  assign fire     = busy && out_ready;
  assign accept   = in_ready && in_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      work_mask <= '0;
      seq       <= '0;
`ifdef PENC_ZERO_TOKEN_EN
      zero_tok  <= 1'b0;
`endif
    end else begin
      if (fire) begin
        work_mask <= work_mask & ~lead_oh;
        seq       <= seq + CNT_W'(1);
`ifdef PENC_ZERO_TOKEN_EN
        zero_tok  <= 1'b0;
`endif
        if (out_last) begin
          state <= IDLE;
        end
      end
      // A new mask overrides the completion update from the same cycle.
      if (accept) begin
        work_mask <= in_mask;
        seq       <= '0;
`ifdef PENC_ZERO_TOKEN_EN
        zero_tok  <= (in_mask == '0);
        state     <= BUSY;
`else
        state     <= (in_mask == '0) ? IDLE : BUSY;
`endif
      end
    end
  end

endmodule

// File: tb/tb_pencoder_seq.sv
// tb/tb_pencoder_seq.sv - scoreboard testbench for pencoder_seq (WIDTH=8 and WIDTH=5)
module tb_pencoder_seq;

  typedef struct {
    int idx;
    int seq;
    bit last;
    bit zero;
  } beat_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic       iv8 = 1'b0;
  logic       ir8;
  logic [7:0] im8 = '0;
  logic       ov8;
  logic       or8 = 1'b1;
  logic [2:0] oi8;
  logic [3:0] os8;
  logic       ol8;
  logic       b8;
`ifdef PENC_ZERO_TOKEN_EN
  logic       oz8;
  logic       oz5;
`endif

  logic       iv5 = 1'b0;
  logic       ir5;
  logic [4:0] im5 = '0;
  logic       ov5;
  logic       or5 = 1'b1;
  logic [2:0] oi5;
  logic [2:0] os5;
  logic       ol5;
  logic       b5;

  int total = 0;
  int bad = 0;

  beat_t q8[$];
  beat_t q5[$];

  pencoder_seq #(.WIDTH(8)) d8 (
    .clk(clk), .reset(reset),
    .in_valid(iv8), .in_ready(ir8), .in_mask(im8),
    .out_valid(ov8), .out_ready(or8),
    .out_idx(oi8), .out_seq(os8), .out_last(ol8),
`ifdef PENC_ZERO_TOKEN_EN
    .out_zero(oz8),
`endif
    .busy(b8)
  );

  pencoder_seq #(.WIDTH(5)) d5 (
    .clk(clk), .reset(reset),
    .in_valid(iv5), .in_ready(ir5), .in_mask(im5),
    .out_valid(ov5), .out_ready(or5),
    .out_idx(oi5), .out_seq(os5), .out_last(ol5),
`ifdef PENC_ZERO_TOKEN_EN
    .out_zero(oz5),
`endif
    .busy(b5)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push8(input int i, input int s, input bit l, input bit z = 1'b0);
    beat_t b;
    b.idx = i; b.seq = s; b.last = l; b.zero = z;
    q8.push_back(b);
  endtask

  task automatic push5(input int i, input int s, input bit l);
    beat_t b;
    b.idx = i; b.seq = s; b.last = l; b.zero = 1'b0;
    q5.push_back(b);
  endtask

  // Monitors: pop and compare on every completed handshake.
  always @(negedge clk) begin
    if (ov8 && or8) begin
      if (q8.size() == 0) begin
        chk("beat8 unexpected", {oi8, os8, ol8}, 64'hdead);
      end else begin
        beat_t e;
        e = q8.pop_front();
        chk("beat8 idx/seq/last", {oi8, os8, ol8}, {3'(e.idx), 4'(e.seq), e.last});
`ifdef PENC_ZERO_TOKEN_EN
        chk("beat8 zero", oz8, e.zero);
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (ov5 && or5) begin
      if (q5.size() == 0) begin
        chk("beat5 unexpected", {oi5, os5, ol5}, 64'hdead);
      end else begin
        beat_t e;
        e = q5.pop_front();
        chk("beat5 idx/seq/last", {oi5, os5, ol5}, {3'(e.idx), 3'(e.seq), e.last});
      end
    end
  end

  // Offer a mask and hold it until accepted; returns 1 time unit after the accepting edge.
  task automatic send8(input logic [7:0] m);
    int n = 0;
    iv8 = 1'b1; im8 = m;
    @(negedge clk);
    while (!ir8 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send8 in_ready", ir8, 1'b1);
    @(posedge clk); #1;
    iv8 = 1'b0;
  endtask

  task automatic send5(input logic [4:0] m);
    int n = 0;
    iv5 = 1'b1; im5 = m;
    @(negedge clk);
    while (!ir5 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send5 in_ready", ir5, 1'b1);
    @(posedge clk); #1;
    iv5 = 1'b0;
  endtask

  task automatic wait_idle8();
    int n = 0;
    @(negedge clk);
    while (b8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("idle8", b8, 1'b0);
  endtask

  task automatic wait_idle5();
    int n = 0;
    @(negedge clk);
    while (b5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("idle5", b5, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset: outputs at reset values, offered mask ignored.
    iv8 = 1'b1; im8 = 8'hFF;
    repeat (3) begin
      @(negedge clk);
      chk("rst out_valid", ov8, 1'b0);
      chk("rst in_ready", ir8, 1'b0);
      chk("rst idx/seq/last/busy", {oi8, os8, ol8, b8}, '0);
    end
    @(posedge clk); #1;
    reset = 1'b0; iv8 = 1'b0;
    @(negedge clk);
    chk("post-rst in_ready", ir8, 1'b1);
    chk("post-rst busy", b8, 1'b0);

    // Basic emission 1010_0100 -> idx 0,2,5.
    @(posedge clk); #1;
    push8(0, 0, 0); push8(2, 1, 0); push8(5, 2, 1);
    send8(8'b1010_0100);
    @(negedge clk);
    chk("latency out_valid", ov8, 1'b1);
    wait_idle8();

    // Stall hold on 0000_0011.
    @(posedge clk); #1;
    or8 = 1'b0;
    push8(6, 0, 0); push8(7, 1, 1);
    send8(8'b0000_0011);
    repeat (3) begin
      @(negedge clk);
      chk("stall valid/idx/seq/last", {ov8, oi8, os8, ol8}, {1'b1, 3'd6, 4'd0, 1'b0});
      chk("stall in_ready", ir8, 1'b0);
      @(posedge clk); #1;
    end
    or8 = 1'b1;
    @(negedge clk);
    chk("stall release in_ready", ir8, 1'b0);
    wait_idle8();

    // Back-to-back 8'h81 then 8'h40 offered on the last-beat cycle.
    @(posedge clk); #1;
    push8(0, 0, 0); push8(7, 1, 1); push8(1, 0, 1);
    send8(8'h81);
    iv8 = 1'b1; im8 = 8'h40;
    @(negedge clk);
    chk("b2b first in_ready", ir8, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b last idx", oi8, 3'd7);
    chk("b2b last in_ready", ir8, 1'b1);
    @(posedge clk); #1;
    iv8 = 1'b0;
    @(negedge clk);
    chk("b2b no bubble", {ov8, oi8}, {1'b1, 3'd1});
    wait_idle8();

    // Zero mask.
    @(posedge clk); #1;
`ifdef PENC_ZERO_TOKEN_EN
    push8(0, 0, 1, 1);
    send8(8'h00);
    @(negedge clk);
    chk("zero token valid/last", {ov8, ol8, oz8}, 3'b111);
    wait_idle8();
`else
    send8(8'h00);
    @(negedge clk);
    chk("zero out_valid", ov8, 1'b0);
    chk("zero in_ready", ir8, 1'b1);
    chk("zero busy", b8, 1'b0);
`endif

    // Reset mid-stream: 8'hFF, reset after three beats.
    @(posedge clk); #1;
    push8(0, 0, 0); push8(1, 1, 0); push8(2, 2, 0);
    send8(8'hFF);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("midrst out_valid", ov8, 1'b0);
    chk("midrst in_ready", ir8, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst after in_ready", ir8, 1'b1);
    chk("midrst after out_valid", ov8, 1'b0);
    @(posedge clk); #1;
    push8(7, 0, 1);
    send8(8'h01);
    wait_idle8();

    // WIDTH=5 instance.
    @(posedge clk); #1;
    push5(4, 0, 1);
    send5(5'b00001);
    push5(0, 0, 1);
    send5(5'b10000);
    for (int i = 0; i < 5; i++) push5(i, i, i == 4);
    send5(5'b11111);
    wait_idle5();

    repeat (2) @(negedge clk);
    chk("q8 drained", q8.size(), 0);
    chk("q5 drained", q5.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pencoder_seq.md
# pencoder_seq

Sequential, parametrised priority encoder for the bit-serial datapath. It accepts a WIDTH-bit bitmask through a valid/ready handshake and emits, one per accepted output beat, the MSB-relative index of every set bit. Emission runs from the most significant set bit down, and each emitted bit is cleared from the working mask. The block sits between the operand bit-mask generator and the shift/accumulate PE lanes, so that only essential (non-zero) bits consume cycles.

## Interface
- WIDTH, default 8: mask width; legal range 2..64.
- IDX_W, default $clog2(WIDTH): index width; derived, not overridden.
- CNT_W, default $clog2(WIDTH+1): beat-counter width; derived.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  a mask is offered.
- in_ready  output  1  the block can accept a mask this cycle.
- in_mask  input  WIDTH  bitmask to encode.
- out_valid  output  1  out_idx/out_seq/out_last hold a valid beat.
- out_ready  input  1  the consumer takes the beat.
- out_idx  output  IDX_W  position of the current leading one. Bit WIDTH-1 maps to 0 and bit 0 maps to WIDTH-1.
- out_seq  output  CNT_W  ordinal of this beat within the current mask, starting at 0.
- out_last  output  1  this beat is the final one for the current mask.
- out_zero  output  1  the beat is a zero-mask token; only present with PENC_ZERO_TOKEN_EN.
- busy  output  1  the FSM is in state BUSY.

## Operation
- Registers:
  - work_mask (WIDTH bits)
  - seq counter (CNT_W bits)
  - state, one of {IDLE, BUSY}
  - zero_tok flag (only with the macro)
- IDLE:
  - in_ready=1 and out_valid=0.
  - When in_valid is high in IDLE, work_mask<=in_mask, seq<=0 and state<=BUSY.
  - Zero-mask exception: if in_mask==0 and the macro is off, the mask is consumed and state stays IDLE. No beat is produced.
- BUSY:
  - out_valid=1.
  - out_idx = WIDTH-1-p, where p is the position of the highest set bit of work_mask.
  - out_last = 1 when work_mask has exactly one bit set.
  - out_seq = seq.
- Handshake completion (out_valid & out_ready):
  - The bit at position p is cleared and seq increments.
  - If out_last, state<=IDLE.
- Back-to-back masks: in_ready = IDLE | (BUSY & out_last & out_ready). This is a combinational path from out_ready to in_ready.
  - If a new mask is accepted on the last-beat cycle, the block reloads and stays BUSY (or goes to IDLE if the new mask is zero and the macro is off).
  - No bubble is inserted between masks.
- Output stability: out_idx, out_seq and out_last stay stable while out_valid=1 and out_ready=0. The mask does not change during a stall.
- Beat count: beats per nonzero mask = popcount(in_mask). out_seq runs 0..popcount-1. The counter never wraps, since the maximum value is WIDTH-1 < 2^CNT_W.

## Timing
- Reset values (the same on every cycle that reset is high):
  - state=IDLE, work_mask=0, seq=0.
  - out_valid=0, out_last=0, out_idx=0, out_seq=0, out_zero=0, busy=0.
  - in_ready=0 while reset is high; in_ready=1 on the first cycle after reset deasserts.
- Reset mid-operation: a reset while BUSY discards the current mask. No further beats are emitted.
- Latency: a mask accepted at edge N gives out_valid=1 with its first beat in cycle N+1.
- Throughput: one beat per cycle while out_ready=1. A mask with k set bits occupies k cycles.
- Input ignored when not ready: when in_ready=0, in_valid and in_mask are ignored.
- Single-set-bit mask: out_last=1 on the first beat.
- All-ones mask: WIDTH beats, with out_idx running 0,1,...,WIDTH-1.

## Configuration
- PENC_ZERO_TOKEN_EN defined:
  - A zero mask enters BUSY and emits exactly one beat: out_zero=1, out_last=1, out_idx=0, out_seq=0.
  - On the handshake, state returns to IDLE, or reloads under the back-to-back rule.
  - out_zero=0 on every other beat.
- PENC_ZERO_TOKEN_EN undefined:
  - The out_zero port and zero_tok flag are absent.
  - A zero mask is consumed silently in one cycle (in_ready stays 1) and produces no beats.

## Test plan
- Basic emission: WIDTH=8, mask 8'b1010_0100, out_ready=1 -> out_idx 0,2,5; out_seq 0,1,2; out_last only on the third beat. out_valid rises one cycle after acceptance.
- Stall hold: mask 8'b0000_0011 with out_ready held low for 3 cycles, then high -> out_idx=6 is held stable for 4 cycles, then out_idx=7 with out_last=1. in_ready=0 throughout.
- Back-to-back masks: 8'h81 followed by 8'h40, offered on the last-beat cycle -> out_idx sequence 0,7,1 with no bubble. in_ready=1 on the cycle of the beat with idx=7.
- Zero mask:
  - Macro off: mask 0 -> no out_valid, and in_ready stays 1.
  - Macro on: mask 0 -> one beat with out_zero=1, out_last=1.
- Reset mid-stream: mask 8'hFF, reset asserted after 3 beats -> out_valid=0 on the next cycle and in_ready=1 one cycle after reset drops. A subsequent mask 8'h01 yields a single beat with idx=7, seq=0.
- Parametrisation: WIDTH=5, masks 5'b00001, 5'b10000, 5'b11111 -> single-bit masks give idx 4 and 0; the all-ones mask gives idx 0..4. out_seq reaches 4 without wrap.
